// File: rtl/gcd_sched.sv
// gcd_sched: two-requester subtractive GCD engine with an IDLE/CALC/DONE scheduler
//   WIDTH              operand/result width
//   clk, rst_n         clock, asynchronous active-low reset
//   req0/a0/b0         requester 0 level request and operands
//   req1/a1/b1         requester 1 level request and operands
//   gnt0, gnt1         one-cycle grant pulses (operands captured at that edge)
//   busy               high while not IDLE
//   res/res_valid/res_id  result, one-cycle strobe, owning requester
//   GCD_SCHED_RR_EN    defined: round-robin arbitration; undefined: req0 fixed priority
module gcd_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, busy_q, busy_d;
  logic res_valid_q, res_valid_d, res_id_q, res_id_d, id_q, id_d;
  logic win, fin;
`ifdef GCD_SCHED_RR_EN
  logic last_q, last_d;
  // on a tie, serve whoever was not served last
  assign win = (req0 && req1) ? ~last_q : req1;
`else
  logic unused_last;
  assign unused_last = 1'b0;
  assign win = ~req0;
`endif
  assign fin = (x_q == '0) || (y_q == '0) || (x_q == y_q);
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    res_d       = res_q;
    id_d        = id_q;
    res_id_d    = res_id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    res_valid_d = 1'b0;
`ifdef GCD_SCHED_RR_EN
    last_d      = last_q;
`endif
    if (state_q == IDLE && (req0 || req1)) begin
      state_d = CALC;
      x_d     = win ? a1 : a0;
      y_d     = win ? b1 : b0;
      gnt0_d  = ~win;
      gnt1_d  = win;
      id_d    = win;
`ifdef GCD_SCHED_RR_EN
      last_d  = win;
`endif
    end else if (state_q == CALC && fin) begin
      state_d     = DONE;
      res_d       = (x_q == '0) ? y_q : x_q;
      res_valid_d = 1'b1;
      res_id_d    = id_q;
    end else if (state_q == CALC) begin
      x_d = (x_q > y_q) ? x_q - y_q : x_q;
      y_d = (x_q > y_q) ? y_q : y_q - x_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      id_q        <= 1'b0;
      res_id_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef GCD_SCHED_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_q       <= res_d;
      id_q        <= id_d;
      res_id_q    <= res_id_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
`ifdef GCD_SCHED_RR_EN
      last_q      <= last_d;
`endif
    end
  end
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = busy_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: randomized self-checking bench for gcd_sched against a behavioural model
module tb_gcd_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, busy, res_valid, res_id;
  logic [15:0] res;
  int checks = 0, failures = 0;
  bit last = 1'b1;
  bit raise1 = 1'b0;
  logic [15:0] pend_a, pend_b;
  gcd_sched #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .res(res), .res_valid(res_valid), .res_id(res_id)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int gcd(input int a, input int b);
    while (b != 0) begin
      int t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  function automatic int steps(input int a, input int b);
    int n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) a -= b; else b -= a;
      n++;
    end
    return n;
  endfunction
  function automatic bit pick(input bit r0, input bit r1);
`ifdef GCD_SCHED_RR_EN
    return (r0 && r1) ? !last : r1;
`else
    return !r0;
`endif
  endfunction
  function automatic logic [15:0] rnd();
    return ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 250));
  endfunction
  // Called with the DUT idle and the requests already driven; the next edge must grant id.
  task automatic job(input bit id, input int a, input int b);
    int n = 0;
    int exp_n = steps(a, b) + 1;
    @(posedge clk); #1;
    check("gnt0", gnt0, !id);
    check("gnt1", gnt1, id);
    check("busy_grant", busy, 1);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    last = id;
    if (raise1) begin
      req1 = 1'b1; a1 = pend_a; b1 = pend_b; raise1 = 1'b0;
    end
    while (!res_valid && n <= 1000) begin
      @(posedge clk); #1;
      n++;
      if (!res_valid) check("gnt_calc", {gnt0, gnt1}, 0);
    end
    check("latency", n, exp_n);
    check("res", res, gcd(a, b));
    check("res_id", res_id, id);
    check("busy_done", busy, 1);
    @(posedge clk); #1;
    check("res_valid_drop", res_valid, 0);
    check("busy_idle", busy, 0);
    check("gnt_idle", {gnt0, gnt1}, 0);
    check("res_hold", res, gcd(a, b));
  endtask
  task automatic check_zero(input string tag);
    check(tag, {gnt0, gnt1, busy, res_valid, res_id, res}, 0);
  endtask
  task automatic dual(input logic [15:0] x0, y0, x1, y1);
    bit first;
    req0 = 1'b1; a0 = x0; b0 = y0;
    req1 = 1'b1; a1 = x1; b1 = y1;
    first = pick(1'b1, 1'b1);
    if (first) begin
      job(1'b1, x1, y1);
      job(1'b0, x0, y0);
    end else begin
      job(1'b0, x0, y0);
      job(1'b1, x1, y1);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle_no_req");
    req0 = 1'b1; a0 = 16'd8; b0 = 16'd6;
    job(1'b0, 8, 6);
    req1 = 1'b1; a1 = 16'd14; b1 = 16'd15;
    job(1'b1, 14, 15);
    dual(16'd12, 16'd18, 16'd9, 16'd0);
    dual(16'd12, 16'd18, 16'd9, 16'd0);
    req0 = 1'b1; a0 = 16'd0; b0 = 16'd0;
    job(1'b0, 0, 0);
    req0 = 1'b1; a0 = 16'd0; b0 = 16'd7;
    job(1'b0, 0, 7);
    req0 = 1'b1; a0 = 16'd40; b0 = 16'd6;
    raise1 = 1'b1; pend_a = 16'd21; pend_b = 16'd35;
    job(1'b0, 40, 6);
    job(1'b1, 21, 35);
    req0 = 1'b1; a0 = 16'd1; b0 = 16'd65535;
    @(posedge clk); #1;
    check("gnt0_long", gnt0, 1);
    req0 = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    last = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("no_res_after_abort", {res_valid, busy}, 0);
    end
    req0 = 1'b1; a0 = 16'd27; b0 = 16'd36;
    job(1'b0, 27, 36);
    for (int i = 0; i < 25; i++) begin
      int mode = $urandom_range(0, 2);
      logic [15:0] x0 = rnd(), y0 = rnd(), x1 = rnd(), y1 = rnd();
      if (mode == 0) begin
        req0 = 1'b1; a0 = x0; b0 = y0;
        job(1'b0, x0, y0);
      end else if (mode == 1) begin
        req1 = 1'b1; a1 = x1; b1 = y1;
        job(1'b1, x1, y1);
      end else dual(x0, y0, x1, y1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
